// File: rtl/uart_tx.sv
// uart_tx -- 8N1 serial transmitter with a one-byte holding register.
//
// Frame: start bit (0), data[0]..data[7], stop bit (1); every bit is held for
// BAUDRATE clk cycles. A byte written while a frame is on the line waits in the
// holding register and goes out back-to-back with no idle gap.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   send request, accepted when ready=1
//   data   in   byte to send, sampled with start
//   ready  out  holding register empty
//   busy   out  frame on the line
//   tx     out  registered serial line, idle high

`ifndef B115200
`define B115200 104
`endif

module uart_tx #(
  parameter int BAUDRATE = `B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);
  localparam int            CW        = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUDRATE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_baud, w_baud_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic [7:0]    r_hold, w_hold_n;
  logic          r_hv, w_hv_n;
  logic          r_tx, w_tx_n;
  logic          w_tick, w_accept, w_load;

  assign w_tick   = (r_baud == BAUD_LAST);
  // A pending transfer keeps hv set at that edge, so start is refused there.
  assign w_accept = start && !r_hv;

  assign ready = !r_hv;
  assign busy  = (r_state != IDLE);
  assign tx    = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_hv    <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_hold  <= w_hold_n;
      r_hv    <= w_hv_n;
      r_tx    <= w_tx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_hold_n  = r_hold;
    w_hv_n    = r_hv;
    w_tx_n    = r_tx;
    w_load    = 1'b0;

    if (w_accept) begin
      w_hold_n = data;
      w_hv_n   = 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_tx_n = 1'b1;
        if (r_hv) w_load = 1'b1;
      end
      START: begin
        if (w_tick) begin
          w_state_n = DATA;
          w_tx_n    = r_shift[0];
          w_bit_n   = 3'd0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd7) begin
            w_state_n = STOP;
            w_tx_n    = 1'b1;
            w_bit_n   = 3'd0;
          end else begin
            // bit 0 of the shifter is always the bit currently on the line
            w_shift_n = r_shift >> 1;
            w_tx_n    = r_shift[1];
            w_bit_n   = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_hv) begin
            w_load = 1'b1;
          end else begin
            w_state_n = IDLE;
            w_tx_n    = 1'b1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    // Holding register -> shifter; start bit goes out on this same edge.
    if (w_load) begin
      w_state_n = START;
      w_shift_n = r_hold;
      w_hv_n    = 1'b0;
      w_baud_n  = '0;
      w_bit_n   = 3'd0;
      w_tx_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at BAUDRATE=4: hand-computed frame table, directed
// multi-cycle sequences, and a random phase, all shadowed by a frame-level
// reference model compared every cycle.

module tb_uart_tx;
  localparam int BAUD  = 4;
  localparam int FRAME = 10 * BAUD;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready, busy, tx;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  uart_tx #(.BAUDRATE(BAUD)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .ready(ready), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Line level of bit slot idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // ---------------- reference model: frames as (byte, elapsed cycles) ----------------
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_q   = 8'h00;
  bit         m_active = 1'b0;
  bit         m_qv     = 1'b0;
  int         m_pos    = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0;
      m_qv     = 1'b0;
      m_pos    = 0;
    end else begin
      bit qv_pre;
      qv_pre = m_qv;
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      if (!m_active && qv_pre) begin
        m_cur    = m_q;
        m_pos    = 0;
        m_active = 1'b1;
        m_qv     = 1'b0;
      end
      if (start && !qv_pre) begin
        m_q  = data;
        m_qv = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("mon_tx",    32'(tx),    32'(m_active ? frame_bit(m_cur, m_pos / BAUD) : 1'b1));
      check("mon_busy",  32'(busy),  32'(m_active));
      check("mon_ready", 32'(ready), 32'(!m_qv));
    end
  end

  // ---------------- trace helpers ----------------
  logic       trace[$];
  logic       btrace[$];
  logic [7:0] exp_q[$];

  task automatic tick();
    @(negedge clk);
    trace.push_back(tx);
    btrace.push_back(busy);
  endtask

  // Compare FRAME cycles per byte in exp_q against the trace from index first.
  task automatic check_trace(input string nm, input int first);
    int good = 0;
    int n    = 0;
    foreach (exp_q[k]) begin
      for (int c = 0; c < FRAME; c++) begin
        int i;
        i = first + k * FRAME + c;
        n++;
        if (i < trace.size() && trace[i] === frame_bit(exp_q[k], c / BAUD) && btrace[i] === 1'b1)
          good++;
      end
    end
    check(nm, 32'(good), 32'(n));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy || !ready), 32'(0));
  endtask

  // From an idle line at a negedge: one-cycle start pulse, then step to the
  // first cycle of the start bit (trace[0]).
  task automatic send_idle(input logic [7:0] b);
    start = 1'b1;
    data  = b;
    @(negedge clk);
    start = 1'b0;
    data  = ~b;
    check("acc_ready_low", 32'(ready), 32'(0));
    check("acc_tx_still_high", 32'(tx), 32'(1));
    trace.delete();
    btrace.delete();
    tick();
    check("lat_tx_fall", 32'(trace[0]), 32'(0));
  endtask

  typedef struct packed {
    logic [7:0] din;
    logic [9:0] pat;   // pat[i] = line level in bit slot i
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{din: 8'h55, pat: 10'h2AA};
    tbl[1] = '{din: 8'hA3, pat: 10'h346};
    tbl[2] = '{din: 8'h0F, pat: 10'h21E};
    tbl[3] = '{din: 8'hFF, pat: 10'h3FE};
    tbl[4] = '{din: 8'h00, pat: 10'h200};
    tbl[5] = '{din: 8'hC6, pat: 10'h38C};
    tbl[6] = '{din: 8'h81, pat: 10'h302};

    // Reset acts without a clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_tx",    32'(tx),    32'(1));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_busy",  32'(busy),  32'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Single frames from idle against hand-computed patterns
    for (int k = 0; k < 7; k++) begin
      int good;
      wait_idle();
      send_idle(tbl[k].din);
      while (trace.size() < FRAME + 1) tick();
      good = 0;
      for (int i = 0; i < FRAME; i++)
        if (trace[i] === tbl[k].pat[i / BAUD] && btrace[i] === 1'b1) good++;
      check($sformatf("tbl_frame_%02h", tbl[k].din), 32'(good), 32'(FRAME));
      check($sformatf("tbl_end_%02h", tbl[k].din), 32'({trace[FRAME], btrace[FRAME]}), 32'(2'b10));
    end

    // Back-to-back: 0xA3, 0x0F queued mid-frame, 0xFF refused while full
    wait_idle();
    send_idle(8'hA3);
    repeat (10) tick();
    check("b2b_ready_mid", 32'(ready), 32'(1));
    start = 1'b1; data = 8'h0F;
    tick();
    start = 1'b0;
    check("b2b_queued", 32'(ready), 32'(0));
    start = 1'b1; data = 8'hFF;
    tick();
    start = 1'b0; data = 8'h00;
    check("b2b_still_full", 32'(ready), 32'(0));
    while (trace.size() < 2 * FRAME + 1) tick();
    exp_q.delete();
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    check_trace("b2b_frames", 0);
    check("b2b_end", 32'({trace[2*FRAME], btrace[2*FRAME]}), 32'(2'b10));
    repeat (8) tick();
    check("b2b_no_third", 32'({tx, busy}), 32'(2'b10));

    // Reset during data bit 3 of 0x00 with 0x3C queued
    wait_idle();
    send_idle(8'h00);
    repeat (4) tick();
    start = 1'b1; data = 8'h3C;
    tick();
    start = 1'b0;
    check("rst_seq_queued", 32'(ready), 32'(0));
    while (trace.size() < 18) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx",    32'(tx),    32'(1));
    check("rst_mid_busy",  32'(busy),  32'(0));
    check("rst_mid_ready", 32'(ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    begin
      int quiet = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (tx === 1'b1 && busy === 1'b0 && ready === 1'b1) quiet++;
      end
      check("rst_no_residue", 32'(quiet), 32'(20));
    end
    send_idle(8'hC6);
    while (trace.size() < FRAME + 1) tick();
    exp_q.delete();
    exp_q.push_back(8'hC6);
    check_trace("rst_then_c6", 0);
    check("rst_then_c6_end", 32'({trace[FRAME], btrace[FRAME]}), 32'(2'b10));

    // start held high: continuous 0x81 frames
    wait_idle();
    start = 1'b1; data = 8'h81;
    @(negedge clk);
    check("hold_acc", 32'(ready), 32'(0));
    trace.delete();
    btrace.delete();
    while (trace.size() < 3 * FRAME) tick();
    start = 1'b0;
    exp_q.delete();
    repeat (3) exp_q.push_back(8'h81);
    check_trace("hold_frames", 0);

    // Random traffic, occasional asynchronous reset; model checks every cycle
    wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    start = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUDRATE, default `B115200 (104 clocks per bit at 12 MHz), meaning the bit period in clk cycles; legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to send the byte on data; sampled on the rising edge of clk.
REQ-005 SHALL have port data  input  8  byte to transmit; sampled with start.
REQ-006 SHALL have port ready  output  1  holding register empty; a byte can be accepted.
REQ-007 SHALL have port busy  output  1  a frame is on the line (state != IDLE).
REQ-008 SHALL have port tx  output  1  serial output, registered, idle high.

Function
REQ-009 SHALL transmit 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-010 SHALL hold every bit on tx for exactly BAUDRATE clk cycles, so one frame lasts exactly 10*BAUDRATE cycles.
REQ-011 SHALL contain an internal baud counter of width clog2(BAUDRATE), cleared whenever a frame is loaded and wrapping at BAUDRATE-1.
REQ-012 SHALL contain a one-byte holding register with valid flag hv; ready = !hv.
REQ-013 SHALL capture data into the holding register and set hv at any edge where start=1 and ready=1.
REQ-014 SHALL ignore start while ready=0; the holding register is not overwritten.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 SHALL, in IDLE with hv=1, at the next edge: load the shift register from the holding register, clear hv, enter START, drive tx=0.
REQ-017 SHALL give a latency of 2 edges from the accepting start edge to tx falling, when idle.
REQ-018 SHALL move from START to DATA after BAUDRATE cycles, and DATA shifts one bit per BAUDRATE cycles.
REQ-019 SHALL move from DATA to STOP after the 8th bit period, using a 3-bit bit counter.
REQ-020 SHALL, at the end of STOP, go directly to START with hv=1 (load as in REQ-016), giving back-to-back frames with zero idle cycles.
REQ-021 SHALL, at the end of STOP with hv=0, go to IDLE with tx=1.
REQ-022 SHALL, on simultaneous start and holding-to-shifter transfer at one edge, ignore start because ready=0 at that edge; start is accepted on the following edge.
REQ-023 SHALL not disturb the frame in progress when the holding register is written during transmission.
REQ-024 SHALL keep data changes after acceptance from affecting the queued or current byte.

Reset
REQ-025 SHALL, while rst=1, force tx=1, ready=1, busy=0, state=IDLE, hv=0, and clear the baud and bit counters, regardless of clk.
REQ-026 SHALL abort any frame in progress on reset (tx returns to 1 immediately) and discard the queued byte.
REQ-027 SHALL, after rst deasserts, not start a frame until a new start is accepted.

Verification (BAUDRATE=4)
REQ-028 SHALL cover: assert rst -> tx=1, ready=1, busy=0 with no clk edge required.
REQ-029 SHALL cover: start with 0x55 for 1 cycle -> tx low 2 edges later; tx sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles each; busy high 40 cycles.
REQ-030 SHALL cover: 0xA3 sent, then 0x0F accepted mid-frame (ready=1 again) -> second start bit begins on the cycle after the first stop bit ends; 80 contiguous cycles.
REQ-031 SHALL cover: third start (0xFF) while ready=0 with 0x0F queued -> ignored; only 0xA3 and 0x0F appear on tx.
REQ-032 SHALL cover: rst pulse during data bit 3 of 0x00 -> tx=1 asynchronously, busy=0, ready=1; then send 0xC6 -> correct frame with no residue.
REQ-033 SHALL cover: start held high continuously with data=0x81 -> contiguous frames, each exactly 40 cycles, and the bit pattern is correct each time.
